// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller.
// Purpose : ALU opcode encodings, lane ids, condition-code bit positions,
//           controller state type and a small opcode helper.
// Ports   : none (package).
package alu_share_ctrl_pkg;

  // 4-bit ALU opcode encodings; anything not listed is an undefined op.
  localparam logic [3:0] OP_ADD          = 4'h0;
  localparam logic [3:0] OP_SUB          = 4'h1;
  localparam logic [3:0] OP_AND          = 4'h2;
  localparam logic [3:0] OP_OR           = 4'h3;
  localparam logic [3:0] OP_XOR          = 4'h4;
  localparam logic [3:0] OP_SLL          = 4'h5;
  localparam logic [3:0] OP_SRL          = 4'h6;
  localparam logic [3:0] OP_MULT         = 4'h7;
  localparam logic [3:0] OP_LESS_THAN    = 4'h8;
  localparam logic [3:0] OP_GREATER_THAN = 4'h9;
  localparam logic [3:0] OP_EQUAL        = 4'hA;

  // Requester lanes.
  localparam int LANE_A = 0;  // execute stage
  localparam int LANE_B = 1;  // address/branch unit

  // Condition-code bit positions.
  localparam int CC_BRANCH    = 0;
  localparam int CC_OVERFLOW  = 1;
  localparam int CC_UNDERFLOW = 2;
  localparam int CC_RESERVE   = 3;

  // Hold counter width; covers MULT_CYCLES-1 for MULT_CYCLES up to 8.
  localparam int CNT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  function automatic logic is_mult(input logic [3:0] op);
    return op == OP_MULT;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
// Purpose : grants one of two eligible lanes, preferring the lane that did
//           not win last; the history bit moves only when update is high.
// Ports   : clk, rst (async, active-high), elig[1:0] eligible lanes,
//           update (a grant was taken this cycle), grant[1:0] one-hot grant.
module alu_share_ctrl_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  // With a single eligible lane the eligibility vector is already one-hot.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Reset to lane 1 so lane 0 wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// ALU sharing controller.
// Purpose : arbitrates two requesters onto one external ALU, holds the issue
//           registers for the op duration (multicycle for MULT) and returns
//           result + condition codes through per-lane response registers.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_ready[1:0], req_op[7:0], req_a/req_b[63:0] : requests
//           alu_a, alu_b, alu_op -> ALU ; alu_res, alu_cc <- ALU
//           rsp_valid/rsp_ready[1:0], rsp_data[63:0], rsp_cc[7:0]   : responses
//           busy : an op is in flight
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [7:0]          req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_op,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [3:0]          alu_cc,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic [7:0]          rsp_cc,
  output logic                busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

  state_e             state;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  issue_a;
  logic [DATA_W-1:0]  issue_b;
  logic [3:0]         issue_op;
  logic               issue_owner;

  logic               complete;
  logic               slot_open;
  logic [1:0]         elig;
  logic [1:0]         grant;
  logic               accept;
  logic               acc_lane;
  logic [3:0]         acc_op;
  logic [DATA_W-1:0]  acc_a;
  logic [DATA_W-1:0]  acc_b;

  assign complete  = (state == ST_EXEC) && (count == '0);
  assign slot_open = (state == ST_IDLE) || complete;

  // A lane may issue only if its response slot will be free by its own
  // completion; the completing owner is skipped because its slot is being
  // written on this very edge.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && slot_open &&
                (!rsp_valid[i] || rsp_ready[i]) &&
                !(complete && (issue_owner == 1'(i)));
    end
  end

  alu_share_ctrl_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig   (elig),
    .update (accept),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign acc_lane  = grant[1];
  assign acc_op    = acc_lane ? req_op[7:4]            : req_op[3:0];
  assign acc_a     = acc_lane ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign acc_b     = acc_lane ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];

  // Issue stage: operands held from accept through the completion cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_op    <= '0;
      issue_owner <= 1'b0;
    end else if (accept) begin
      state       <= ST_EXEC;
      count       <= is_mult(acc_op) ? MULT_LOAD : '0;
      issue_a     <= acc_a;
      issue_b     <= acc_b;
      issue_op    <= acc_op;
      issue_owner <= acc_lane;
    end else if (complete) begin
      state <= ST_IDLE;
    end else if (state == ST_EXEC) begin
      count <= count - 1'b1;
    end
  end

  assign alu_a  = issue_a;
  assign alu_b  = issue_b;
  assign alu_op = issue_op;
  assign busy   = (state == ST_EXEC);

  // Response stage: a completion write takes priority over a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_cc    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (complete && (issue_owner == 1'(i))) begin
          rsp_valid[i] <= 1'b1;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
      if (complete) begin
        if (issue_owner) begin
          rsp_data[2*DATA_W-1:DATA_W] <= alu_res;
          rsp_cc[7:4]                 <= alu_cc;
        end else begin
          rsp_data[DATA_W-1:0] <= alu_res;
          rsp_cc[3:0]          <= alu_cc;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl with a behavioural ALU alongside.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic [3:0]  alu_cc;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic [7:0]  rsp_cc;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_W(32), .MULT_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_cc(alu_cc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cc(rsp_cc), .busy(busy)
  );

  // Behavioural ALU: cc = {reserve, underflow(borrow), overflow(signed), branch}.
  always_comb begin
    alu_res = '0;
    alu_cc  = '0;
    case (alu_op)
      OP_ADD: begin
        alu_res = alu_a + alu_b;
        alu_cc[CC_OVERFLOW] = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_res = alu_a - alu_b;
        alu_cc[CC_UNDERFLOW] = alu_a < alu_b;
        alu_cc[CC_OVERFLOW]  = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
      end
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_SLL:  alu_res = alu_a << alu_b[4:0];
      OP_SRL:  alu_res = alu_a >> alu_b[4:0];
      OP_MULT: alu_res = alu_a * alu_b;
      OP_LESS_THAN:    alu_cc[CC_BRANCH] = $signed(alu_a) <  $signed(alu_b);
      OP_GREATER_THAN: alu_cc[CC_BRANCH] = $signed(alu_a) >  $signed(alu_b);
      OP_EQUAL:        alu_cc[CC_BRANCH] = alu_a == alu_b;
      default: ;
    endcase
  end

  // A completion must never land on a lane that is popping on the same edge.
  always @(posedge clk) begin
    if (!rst && dut.complete && rsp_valid[dut.issue_owner] && rsp_ready[dut.issue_owner]) begin
      n_bad++;
      $display("FAIL same_edge_write_pop: lane %0d written while popping", dut.issue_owner);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    n_vec++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin n_bad++; $display("FAIL rst_issue: got %h %h %h want 0", alu_a, alu_b, alu_op); end
    n_vec++; if ({rsp_data, rsp_cc} !== 72'd0) begin n_bad++; $display("FAIL rst_rsp_regs: got %h %h want 0", rsp_data, rsp_cc); end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    req_valid = 2'b01; req_op = {4'h0, OP_ADD}; req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd7};
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL add_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    n_vec++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL add_exec: busy %b rsp_valid %b want 1 00", busy, rsp_valid); end
    step();
    n_vec++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_data[31:0] !== 32'd12) begin n_bad++; $display("FAIL add_data: got %0d want 12", rsp_data[31:0]); end
    n_vec++; if (rsp_cc[3:0] !== 4'b0000) begin n_bad++; $display("FAIL add_cc: got %b want 0000", rsp_cc[3:0]); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL add_idle: busy %b want 0", busy); end
    step();
    n_vec++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL add_pop: got %b want 00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant [4];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    req_valid = 2'b11; req_op = {OP_SUB, OP_ADD};
    req_a = {32'd3, 32'd1}; req_b = {32'd5, 32'd1};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (req_ready !== exp_grant[k]) begin n_bad++; $display("FAIL cont_grant%0d: got %b want %b", k, req_ready, exp_grant[k]); end
      step();
      if (k == 1) begin
        n_vec++; if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== 32'd2) begin n_bad++; $display("FAIL cont_lane0: valid %b data %h want 1 2", rsp_valid[0], rsp_data[31:0]); end
      end
      if (k == 2) begin
        n_vec++; if (rsp_valid[1] !== 1'b1 || rsp_data[63:32] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL cont_lane1_data: valid %b data %h want 1 fffffffe", rsp_valid[1], rsp_data[63:32]); end
        n_vec++; if (rsp_cc[7:4] !== 4'b0100) begin n_bad++; $display("FAIL cont_lane1_cc: got %b want 0100", rsp_cc[7:4]); end
      end
    end
    req_valid = 2'b00;
    repeat (3) step();
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL cont_drain: busy %b rsp_valid %b want 0 00", busy, rsp_valid); end
  endtask

  task automatic test_mult();
    req_valid = 2'b10; req_op = {OP_MULT, 4'h0}; req_a = {32'd6, 32'd0}; req_b = {32'd7, 32'd0};
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL mult_ready: got %b want 10", req_ready); end
    step();
    // Lane 0 arrives mid-op; lane 1 inputs change to prove the issue regs hold.
    req_valid = 2'b01; req_op = {OP_ADD, OP_ADD}; req_a = {32'd99, 32'd10}; req_b = {32'd98, 32'd20};
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy%0d: got %b want 1", c, busy); end
      n_vec++; if (alu_a !== 32'd6 || alu_b !== 32'd7 || alu_op !== OP_MULT) begin n_bad++; $display("FAIL mult_hold%0d: got %0d %0d %h want 6 7 7", c, alu_a, alu_b, alu_op); end
      n_vec++; if (req_ready !== ((c == 2) ? 2'b01 : 2'b00)) begin n_bad++; $display("FAIL mult_wait%0d: req_ready %b", c, req_ready); end
      step();
    end
    req_valid = 2'b00;
    #1;
    n_vec++; if (rsp_valid[1] !== 1'b1 || rsp_data[63:32] !== 32'd42) begin n_bad++; $display("FAIL mult_rsp: valid %b data %0d want 1 42", rsp_valid[1], rsp_data[63:32]); end
    n_vec++; if (busy !== 1'b1 || alu_a !== 32'd10) begin n_bad++; $display("FAIL mult_next_issue: busy %b alu_a %0d want 1 10", busy, alu_a); end
    step();
    n_vec++; if (rsp_valid !== 2'b01 || rsp_data[31:0] !== 32'd30) begin n_bad++; $display("FAIL mult_lane0_rsp: valid %b data %0d want 01 30", rsp_valid, rsp_data[31:0]); end
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 2'b10;
    req_valid = 2'b01; req_op = {4'h0, OP_ADD}; req_a = {32'd0, 32'd2}; req_b = {32'd0, 32'd2};
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_first_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_vec++; if (rsp_valid !== 2'b01 || rsp_data[31:0] !== 32'd4) begin n_bad++; $display("FAIL bp_rsp: valid %b data %0d want 01 4", rsp_valid, rsp_data[31:0]); end
    req_valid = 2'b01; req_a = {32'd0, 32'd8}; req_b = {32'd0, 32'd9};
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_blocked%0d: req_ready %b want 00", c, req_ready); end
      n_vec++; if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== 32'd4) begin n_bad++; $display("FAIL bp_held%0d: valid %b data %0d want 1 4", c, rsp_valid[0], rsp_data[31:0]); end
      step();
    end
    rsp_ready = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_release_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b1 || alu_a !== 32'd8) begin n_bad++; $display("FAIL bp_accept: valid %b busy %b alu_a %0d want 00 1 8", rsp_valid, busy, alu_a); end
    step();
    n_vec++; if (rsp_valid !== 2'b01 || rsp_data[31:0] !== 32'd17) begin n_bad++; $display("FAIL bp_second: valid %b data %0d want 01 17", rsp_valid, rsp_data[31:0]); end
    step();
  endtask

  task automatic test_compare_undef();
    logic [3:0] ops [3];
    logic [3:0] exp_cc [3];
    ops[0] = 4'hF;         exp_cc[0] = 4'b0000;
    ops[1] = OP_LESS_THAN; exp_cc[1] = 4'b0001;
    ops[2] = OP_GREATER_THAN; exp_cc[2] = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b01; req_op = {4'h0, ops[k]}; req_a = {32'd0, 32'h80000000}; req_b = {32'd0, 32'd1};
      step();
      req_valid = 2'b00;
      step();
      n_vec++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL cmp%0d_valid: got %b want 01", k, rsp_valid); end
      n_vec++; if (rsp_data[31:0] !== 32'd0 || rsp_cc[3:0] !== exp_cc[k]) begin n_bad++; $display("FAIL cmp%0d_result: data %h cc %b want 0 %b", k, rsp_data[31:0], rsp_cc[3:0], exp_cc[k]); end
      step();
    end
  endtask

  task automatic test_async_reset();
    req_valid = 2'b10; req_op = {OP_MULT, 4'h0}; req_a = {32'd5, 32'd0}; req_b = {32'd5, 32'd0};
    step();
    req_valid = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL arst_state: valid %b busy %b want 00 0", rsp_valid, busy); end
    n_vec++; if (alu_a !== 32'd0 || req_ready !== 2'b00) begin n_bad++; $display("FAIL arst_issue: alu_a %0d ready %b want 0 00", alu_a, req_ready); end
    req_valid = 2'b11; req_op = {OP_MULT, OP_ADD}; req_a = {32'd5, 32'd1}; req_b = {32'd5, 32'd2};
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL arst_idle_grant: got %b want 01", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
    req_valid = 2'b00;
    #1;
    n_vec++; if (busy !== 1'b1 || alu_a !== 32'd1 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL arst_first: busy %b alu_a %0d valid %b want 1 1 00", busy, alu_a, rsp_valid); end
    step();
    n_vec++; if (rsp_valid !== 2'b01 || rsp_data[31:0] !== 32'd3) begin n_bad++; $display("FAIL arst_rsp: valid %b data %0d want 01 3", rsp_valid, rsp_data[31:0]); end
    repeat (4) step();
    n_vec++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL arst_dropped: valid %b busy %b want 00 0", rsp_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_add();
    test_mult();
    test_backpressure();
    test_compare_undef();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences and shares a single ALU instance between two requesters; lane 0 is the execute stage, lane 1 is the address/branch unit.
- Round-robin arbitration; operands are latched into issue registers that drive the ALU.
- MULT is held for a multicycle window; all other ops complete in 1 cycle.
- Results and condition codes are returned through a per-requester response register with a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width; the ALU is 32-bit, so this is fixed at 32.
- MULT_CYCLES, 2, cycles the ALU inputs are held for MULT. Legal range 1..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- req_valid  in  2  per-lane request valid; bit i = lane i.
- req_ready  out  2  per-lane accept. A request transfers when valid & ready on the same edge.
- req_op  in  8  lane i opcode at [4i+3:4i]; uses the shared ALU opcode encodings.
- req_a  in  64  lane i operand A at [32i+31:32i].
- req_b  in  64  lane i operand B at [32i+31:32i].
- alu_a  out  32  to ALU operand a; driven from the issue register.
- alu_b  out  32  to ALU operand b; driven from the issue register.
- alu_op  out  4  to ALU opcode; driven from the issue register.
- alu_res  in  32  from ALU result.
- alu_cc  in  4  from ALU condition codes: [reserve, underflow, overflow, branch-true].
- rsp_valid  out  2  per-lane response valid.
- rsp_ready  in  2  per-lane response accept.
- rsp_data  out  64  lane i result at [32i+31:32i].
- rsp_cc  out  8  lane i condition codes at [4i+3:4i].
- busy  out  1  high while an op is in flight.

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - state=IDLE; issue regs, count, rsp_data, rsp_cc = 0.
  - rsp_valid=0, busy=0, last_grant=1, so lane 0 wins first.
- FSM states: IDLE, EXEC.
  - IDLE -> EXEC on accept.
  - In EXEC, count decrements each cycle. The cycle with count==0 is the completion cycle.
  - Completion cycle:
    - alu_res/alu_cc are written into the owner lane's rsp register and rsp_valid[owner] is set.
    - Next state is EXEC if a new request is accepted in the same cycle, otherwise IDLE.
- Count load on accept: MULT_CYCLES-1 if op==MULT, else 0.
- Latency: accept at edge N -> rsp_valid high after edge N+1 (non-MULT) or N+MULT_CYCLES (MULT).
- Throughput: back-to-back non-MULT ops, one per cycle.
- Lane i is eligible when all of the following hold:
  - req_valid[i] is high;
  - the controller is in IDLE or in the completion cycle;
  - rsp_valid[i]==0, or rsp_ready[i]==1 in this cycle;
  - lane i is not the owner of the op completing this cycle.
- Completion-cycle exclusion: no same-lane back-to-back issue in a completion cycle. The slot is not yet written, so that lane waits 1 cycle.
- Arbitration:
  - If both lanes are eligible, grant the lane != last_grant.
  - If one lane is eligible, grant it.
  - last_grant updates only on accept.
- req_ready[i] is high only for the granted lane. It is combinational from valid/state/rsp and has no dependency on alu_res.
- Issue registers (a, b, op, owner) load only on accept and are held stable for the whole EXEC window. alu_* outputs never change mid-op.
- Response register:
  - Once rsp_valid[i]=1, rsp_data/rsp_cc for that lane are held until rsp_ready[i].
  - Pop clears rsp_valid[i] unless the same edge writes a new completion to that lane. A same-edge write is impossible given the eligibility rules; the bench asserts it never happens.
- Opcodes outside the defined set are issued as 1-cycle ops. The ALU returns 0/0 and that is passed back unmodified.
- Compare ops return alu_res=0 and the branch result in cc[0], passed through verbatim.
- busy = (state==EXEC).
- Reset mid-op: the in-flight op and pending responses are dropped; no rsp_valid after release.

Decomposition:
- Shared package/include: the existing 4-bit ALU opcode defines (MULT used here), LANE_A=0, LANE_B=1, CC bit index constants.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant state and an update enable.
- The ALU itself stays outside; it is instantiated alongside this block in the datapath.

Test Plan:
- Single ADD, lane 0: a=5, b=7 -> rsp_valid[0] one cycle after accept, rsp_data[31:0]=12, cc=0000.
- Contention: both lanes valid every cycle, lane 0 ADD 1+1, lane 1 SUB 3-5.
  - Required grant order 0,1,0,1.
  - Lane 1 gets 0xFFFFFFFE with cc[2]=1.
- MULT with MULT_CYCLES=3: lane 1, a=6, b=7.
  - busy high for 3 cycles, alu_a/alu_b stable throughout.
  - rsp_data[63:32]=42.
  - A lane 0 request arriving mid-op waits until the completion cycle.
- Backpressure: lane 0 holds rsp_ready=0 after ADD 2+2.
  - A second lane 0 request stays unaccepted.
  - rsp_data stays 4.
  - Raising rsp_ready accepts the new request on that same edge.
- Compare: LESS_THAN a=0x80000000, b=1 -> cc[0]=1. GREATER_THAN same operands -> cc[0]=0.
- Async reset asserted during a MULT EXEC -> rsp_valid=0, busy=0, req_ready reflects IDLE; first grant after release goes to lane 0.
